// File: rtl/multi_trigger_block.sv
// Multi-probe trigger unit on the daisy-chained register bus: per-probe op/arg compare, OR/AND combine, arm-gated sticky trigger.
// Define TRIGGER_HOLDOFF_EN to add the holdoff register and consecutive-hit run counter.
module multi_trigger_block #(
    parameter int BASE_ADDR   = 0,
    parameter int N_PROBES    = 4,
    parameter int PROBE_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_PROBES*PROBE_WIDTH-1:0] probes_i,
    output logic                            trig_o,
    input  logic [15:0]                     addr_i,
    input  logic [15:0]                     wdata_i,
    input  logic [15:0]                     rdata_i,
    input  logic                            rw_i,
    input  logic                            valid_i,
    output logic [15:0]                     addr_o,
    output logic [15:0]                     wdata_o,
    output logic [15:0]                     rdata_o,
    output logic                            rw_o,
    output logic                            valid_o
);

    localparam int CTRL_OFF = 2 * N_PROBES;
    localparam int STAT_OFF = 2 * N_PROBES + 1;
`ifdef TRIGGER_HOLDOFF_EN
    localparam int HOLD_OFF = 2 * N_PROBES + 2;
    localparam int N_REGS   = 2 * N_PROBES + 3;
`else
    localparam int N_REGS   = 2 * N_PROBES + 2;
`endif

    logic [3:0]                      op_q   [N_PROBES];
    logic [PROBE_WIDTH-1:0]          arg_q  [N_PROBES];
    logic [1:0]                      ctrl_q;
    logic [N_PROBES*PROBE_WIDTH-1:0] prev_q;
    logic                            prev_valid_q;
    logic                            trig_q, trig_d;
    logic [15:0]                     rdata_q, rdata_d;
    logic [15:0]                     addr_q, wdata_q;
    logic                            rw_q, valid_q;

    logic [16:0]         off_s;
    logic                in_range_s, wr_s, rd_s, disarm_s, hold_ok_s, hit_s;
    logic [15:0]         rd_val_s;
    logic [N_PROBES-1:0] probe_hit_s, probe_en_s;

    // Offset arithmetic in 17 bits so addresses below BASE_ADDR never alias into range.
    assign off_s      = {1'b0, addr_i} - 17'(BASE_ADDR);
    assign in_range_s = ({1'b0, addr_i} >= 17'(BASE_ADDR)) && (off_s < 17'(N_REGS));
    assign wr_s       = valid_i && rw_i && in_range_s;
    assign rd_s       = valid_i && !rw_i && in_range_s;
    assign disarm_s   = wr_s && (off_s == 17'(CTRL_OFF)) && !wdata_i[1];

    // Per-probe compare; edge ops look at last cycle's sample and stay quiet until it exists.
    always_comb begin
        probe_hit_s = '0;
        probe_en_s  = '0;
        for (int p = 0; p < N_PROBES; p++) begin
            logic [PROBE_WIDTH-1:0] now_v, prv_v;
            now_v = probes_i[p*PROBE_WIDTH +: PROBE_WIDTH];
            prv_v = prev_q[p*PROBE_WIDTH +: PROBE_WIDTH];
            probe_en_s[p] = (op_q[p] >= 4'd1) && (op_q[p] <= 4'd9);
            case (op_q[p])
                4'd1:    probe_hit_s[p] = prev_valid_q && (prv_v == '0) && (now_v != '0);
                4'd2:    probe_hit_s[p] = prev_valid_q && (prv_v != '0) && (now_v == '0);
                4'd3:    probe_hit_s[p] = prev_valid_q && (prv_v != now_v);
                4'd4:    probe_hit_s[p] = now_v >  arg_q[p];
                4'd5:    probe_hit_s[p] = now_v <  arg_q[p];
                4'd6:    probe_hit_s[p] = now_v >= arg_q[p];
                4'd7:    probe_hit_s[p] = now_v <= arg_q[p];
                4'd8:    probe_hit_s[p] = now_v == arg_q[p];
                4'd9:    probe_hit_s[p] = now_v != arg_q[p];
                default: probe_hit_s[p] = 1'b0;
            endcase
        end
    end

    // Disabled probes drop out of both combine modes; with none enabled there is no hit.
    always_comb begin
        if (probe_en_s == '0) begin
            hit_s = 1'b0;
        end else if (ctrl_q[0]) begin
            hit_s = &(probe_hit_s | ~probe_en_s);
        end else begin
            hit_s = |(probe_hit_s & probe_en_s);
        end
    end

`ifdef TRIGGER_HOLDOFF_EN
    logic [15:0] holdoff_q, cnt_q, cnt_d;

    // Saturating run length of consecutive armed hits.
    always_comb begin
        if (ctrl_q[1] && hit_s) begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
        end
    end
    assign hold_ok_s = (cnt_q >= holdoff_q);

    // Holdoff register and run counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            holdoff_q <= 16'd0;
            cnt_q     <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
            if (wr_s && (off_s == 17'(HOLD_OFF))) begin
                holdoff_q <= wdata_i;
            end
        end
    end
`else
    assign hold_ok_s = 1'b1;
`endif

    // Sticky trigger; a disarm write in the hit cycle wins.
    always_comb begin
        if (disarm_s) begin
            trig_d = 1'b0;
        end else if (!ctrl_q[1]) begin
            trig_d = 1'b0;
        end else begin
            trig_d = trig_q | (hit_s & hold_ok_s);
        end
    end

    // Register readback, zero-extended to the bus width.
    always_comb begin
        rd_val_s = 16'h0000;
        for (int p = 0; p < N_PROBES; p++) begin
            if (off_s == 17'(2 * p)) begin
                rd_val_s = {12'h000, op_q[p]};
            end else if (off_s == 17'(2 * p + 1)) begin
                rd_val_s = 16'(arg_q[p]);
            end else begin
                rd_val_s = rd_val_s;
            end
        end
        if (off_s == 17'(CTRL_OFF)) begin
            rd_val_s = {14'h0000, ctrl_q};
        end else if (off_s == 17'(STAT_OFF)) begin
            rd_val_s = {14'h0000, ctrl_q[1], trig_q};
`ifdef TRIGGER_HOLDOFF_EN
        end else if (off_s == 17'(HOLD_OFF)) begin
            rd_val_s = holdoff_q;
`endif
        end else begin
            rd_val_s = rd_val_s;
        end
        rdata_d = rd_s ? rd_val_s : rdata_i;
    end

    // Bus pipeline, configuration registers, previous-sample capture and trigger state.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            rdata_q      <= 16'h0000;
            rw_q         <= 1'b0;
            valid_q      <= 1'b0;
            ctrl_q       <= 2'b00;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            trig_q       <= 1'b0;
            for (int p = 0; p < N_PROBES; p++) begin
                op_q[p]  <= 4'd0;
                arg_q[p] <= '0;
            end
        end else begin
            addr_q       <= addr_i;
            wdata_q      <= wdata_i;
            rdata_q      <= rdata_d;
            rw_q         <= rw_i;
            valid_q      <= valid_i;
            prev_q       <= probes_i;
            prev_valid_q <= 1'b1;
            trig_q       <= trig_d;
            if (wr_s) begin
                for (int p = 0; p < N_PROBES; p++) begin
                    if (off_s == 17'(2 * p)) begin
                        op_q[p] <= wdata_i[3:0];
                    end
                    if (off_s == 17'(2 * p + 1)) begin
                        arg_q[p] <= wdata_i[PROBE_WIDTH-1:0];
                    end
                end
                if (off_s == 17'(CTRL_OFF)) begin
                    ctrl_q <= wdata_i[1:0];
                end
            end
        end
    end

    assign trig_o  = trig_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign rdata_o = rdata_q;
    assign rw_o    = rw_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_multi_trigger_block.sv
// Scoreboard bench for multi_trigger_block at default parameters (holdoff feature off).
module tb_multi_trigger_block;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] probes_i;
    logic        trig_o;
    logic [15:0] addr_i, wdata_i, rdata_i, addr_o, wdata_o, rdata_o;
    logic        rw_i, valid_i, rw_o, valid_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] rdata;
        logic        trig;
        logic [33:0] echo;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    multi_trigger_block #(.BASE_ADDR(0), .N_PROBES(4), .PROBE_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .probes_i(probes_i), .trig_o(trig_o),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one bus/probe cycle, queue its expected outcome, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic [15:0] a, input logic [15:0] w,
                        input logic rwv, input logic vld, input logic [15:0] rdin, input logic [31:0] pr,
                        input logic [15:0] exp_rd, input logic exp_tr);
        exp_t e;
        rst = r; addr_i = a; wdata_i = w; rw_i = rwv; valid_i = vld; rdata_i = rdin; probes_i = pr;
        e.tag = tag; e.rdata = exp_rd; e.trig = exp_tr;
        e.echo = r ? 34'h0 : {a, w, rwv, vld};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({e.tag, "_trig"}, 64'(trig_o), 64'(e.trig));
        chk({e.tag, "_rdata"}, 64'(rdata_o), 64'(e.rdata));
        chk({e.tag, "_bus"}, 64'({addr_o, wdata_o, rw_o, valid_o}), 64'(e.echo));
    endtask

    task automatic wr(input string tag, input logic [15:0] a, input logic [15:0] d, input logic [31:0] pr, input logic et);
        step(tag, 1'b0, a, d, 1'b1, 1'b1, 16'h1234, pr, 16'h1234, et);
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] rdin, input logic [31:0] pr,
                      input logic [15:0] erd, input logic et);
        step(tag, 1'b0, a, 16'h0000, 1'b0, 1'b1, rdin, pr, erd, et);
    endtask

    task automatic idle(input string tag, input logic [31:0] pr, input logic et);
        step(tag, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hA5A5, pr, 16'hA5A5, et);
    endtask

    initial begin
        // Reset while a write to ctrl is presented: it must not land.
        step("rst0", 1'b1, 16'd8, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 32'hFFFF_FFFF, 16'h0000, 1'b0);
        step("rst1", 1'b1, 16'd8, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 32'h0, 16'h0000, 1'b0);
        for (int i = 0; i < 10; i++) rd($sformatf("rd_rst%0d", i), 16'(i), 16'hFFFF, 32'h0, 16'h0000, 1'b0);
        rd("rd_oor", 16'd10, 16'hBEEF, 32'h0, 16'hBEEF, 1'b0);
        for (int i = 0; i < 6; i++) idle("quiet", $urandom, 1'b0);

        // Equality trigger, sticky until disarm.
        wr("op0_eq", 16'd0, 16'd8, 32'h0, 1'b0);
        wr("arg0", 16'd1, 16'h005A, 32'h0, 1'b0);
        wr("arm_or", 16'd8, 16'h0002, 32'h0, 1'b0);
        idle("p0_00", 32'h0000_0000, 1'b0);
        idle("p0_5a", 32'h0000_005A, 1'b1);
        idle("hold_a", 32'h0, 1'b1);
        idle("hold_b", 32'h0, 1'b1);
        rd("stat_trig", 16'd9, 16'h0000, 32'h0, 16'h0003, 1'b1);
        wr("disarm", 16'd8, 16'h0000, 32'h0, 1'b0);
        rd("stat_clr", 16'd9, 16'h0000, 32'h0, 16'h0000, 1'b0);
        step("novalid", 1'b0, 16'd8, 16'h0002, 1'b1, 1'b0, 16'h4321, 32'h0, 16'h4321, 1'b0);
        rd("ctrl_nv", 16'd8, 16'hFFFF, 32'h0, 16'h0000, 1'b0);

        // AND mode: rising on probe0 and probe1 > 0x10.
        wr("op0_rise", 16'd0, 16'd1, 32'h0, 1'b0);
        wr("op1_gt", 16'd2, 16'd4, 32'h0, 1'b0);
        wr("arg1", 16'd3, 16'h0010, 32'h0, 1'b0);
        wr("arm_and", 16'd8, 16'h0003, 32'h0000_0500, 1'b0);
        idle("and_lo", 32'h0000_0501, 1'b0);
        idle("and_p0lo", 32'h0000_0500, 1'b0);
        idle("and_fall", 32'h0000_2000, 1'b0);
        idle("and_hi", 32'h0000_2001, 1'b1);
        wr("and_off", 16'd8, 16'h0000, 32'h0000_2001, 1'b0);
        rd("ctrl_rb0", 16'd8, 16'h0000, 32'h0, 16'h0000, 1'b0);

        // Disarm in the same cycle as the first hit.
        wr("op1_off", 16'd2, 16'd0, 32'h0, 1'b0);
        wr("arm_race", 16'd8, 16'h0002, 32'h0, 1'b0);
        wr("race", 16'd8, 16'h0000, 32'h0000_0001, 1'b0);
        rd("stat_race", 16'd9, 16'hFFFF, 32'h0000_0001, 16'h0000, 1'b0);

        // >= boundary on probe2.
        wr("op2_ge", 16'd4, 16'd6, 32'h0000_0001, 1'b0);
        wr("arg2", 16'd5, 16'h0040, 32'h0000_0001, 1'b0);
        wr("arm_ge", 16'd8, 16'h0002, 32'h0000_0001, 1'b0);
        idle("ge_3f", 32'h003F_0001, 1'b0);
        idle("ge_40", 32'h0040_0001, 1'b1);
        wr("ge_off", 16'd8, 16'h0000, 32'h0, 1'b0);
        rd("arg2_rb", 16'd5, 16'h0000, 32'h0, 16'h0040, 1'b0);

        // Reserved and disabled ops never fire; truncation on write.
        wr("op0_12", 16'd0, 16'd12, 32'h0, 1'b0);
        wr("op2_0", 16'd4, 16'd0, 32'h0, 1'b0);
        wr("arm_all", 16'd8, 16'h0003, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) idle("dis", $urandom, 1'b0);
        wr("op0_1f", 16'd0, 16'h001F, 32'h0, 1'b0);
        rd("op0_rb", 16'd0, 16'h0000, 32'h0, 16'h000F, 1'b0);
        wr("arg1_w", 16'd3, 16'hABCD, 32'h0, 1'b0);
        rd("arg1_rb", 16'd3, 16'h0000, 32'h0, 16'h00CD, 1'b0);
        rd("ctrl_rb3", 16'd8, 16'h0000, 32'h0, 16'h0003, 1'b0);
        rd("stat_arm", 16'd9, 16'h0000, 32'h0, 16'h0002, 1'b0);
        wr("stat_w", 16'd9, 16'h0000, 32'h0, 1'b0);
        rd("stat_ro", 16'd9, 16'h0000, 32'h0, 16'h0002, 1'b0);

        // Reset during a read drops it and clears config.
        step("rst_mid", 1'b1, 16'd8, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 32'h0, 16'h0000, 1'b0);
        rd("ctrl_post", 16'd8, 16'hFFFF, 32'h0, 16'h0000, 1'b0);
        rd("op0_post", 16'd0, 16'hFFFF, 32'h0, 16'h0000, 1'b0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
